direction_input: RTL
====================

# direction_input

Front-end input block for the snake game: it conditions raw push-button inputs into the signals the game core consumes. Four direction buttons and a start button are synchronized and debounced. Direction presses become a latched one-hot `movement` code with reversal filtering. The start button becomes a single-cycle `start` pulse. It sits between the board pins and the game core, driving the core's `movement` and `start` inputs directly from the 50 MHz system clock.

## Interface
- DEBOUNCE_CYCLES, 1000000, consecutive stable cycles required before a button level is accepted (20 ms at 50 MHz); minimum 2
- BLOCK_REVERSE, 1, when 1 a press opposite the current direction is ignored
- clk  input  1  system clock, 50 MHz; all logic on rising edge
- reset_n  input  1  asynchronous, active-low reset; one clock domain
- btn_up  input  1  raw up button, active-high, asynchronous to clk
- btn_down  input  1  raw down button, active-high, asynchronous
- btn_left  input  1  raw left button, active-high, asynchronous
- btn_right  input  1  raw right button, active-high, asynchronous
- btn_start  input  1  raw start button, active-high, asynchronous
- movement  output  4  latched direction: UP=4'b0001, DOWN=4'b0010, LEFT=4'b0100, RIGHT=4'b1000, none=4'b0000
- start  output  1  one-cycle pulse on accepted start press
- dir_change  output  1  one-cycle pulse, coincident with every change of `movement`

## Operation
- Per button (5 total): 2-flop synchronizer, then debouncer.
- Debouncer:
  - Counter restarts whenever the synchronized level differs from the debounced level.
  - Debounced level flips when the counter reaches DEBOUNCE_CYCLES consecutive differing samples.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- Press event: rising edge of a debounced level. Releases generate nothing.
- Direction selection, evaluated each cycle over the direction press events:
  - Candidates are press events that are not the current `movement`.
  - With BLOCK_REVERSE=1, the opposite of the current `movement` is also excluded (UP/DOWN and LEFT/RIGHT are opposites).
  - With `movement`=0000, no candidate is excluded for reversal.
  - Highest-priority remaining candidate wins: UP > DOWN > LEFT > RIGHT.
  - The winner is registered into `movement`, and `dir_change`=1 in the same cycle `movement` takes the new value.
  - No candidate: `movement` is held and `dir_change`=0.
- Start:
  - A debounced rising edge of btn_start gives `start`=1 for exactly one cycle.
  - In the same cycle it clears `movement` to 0000. `dir_change` pulses only if `movement` was nonzero.
- Start and a direction press event in the same cycle: start wins and the direction press is discarded.
- Holding a button does not repeat. A new event needs a debounced release followed by a press.

## Timing
- Reset (asynchronous assert, synchronous release on clk) puts the block in this state:
  - `movement`=0000, `start`=0, `dir_change`=0.
  - All synchronizer flops, debounced levels and counters at 0.
- Latency: a raw input rising at edge k and held stable produces an output change at edge k+DEBOUNCE_CYCLES+3:
  - 2 cycles of synchronizer
  - DEBOUNCE_CYCLES cycles of stability
  - 1 cycle of edge/output register
- Glitch rejection: any pulse shorter than DEBOUNCE_CYCLES cycles after synchronization is filtered, with no output activity.
- Counter saturation and wrap: the counter never exceeds DEBOUNCE_CYCLES and never wraps.
- Reset asserted mid-debounce or mid-pulse: outputs go to reset values immediately. A pending press is lost and must be debounced again after release of reset_n.
- All outputs are registered; no combinational path from any btn_* to any output.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and BLOCK_REVERSE=1.
- Reset: hold reset_n=0 with all buttons high → `movement`=0000, `start`=0, `dir_change`=0. Release reset_n with buttons held → events fire after 7 cycles, `start` wins, `movement`=0000.
- Press btn_right for 20 cycles from `movement`=0000 → `movement`=1000 with a one-cycle `dir_change` exactly 7 edges after the press. No further pulses while held or on release.
- Glitch: 3-cycle pulse on btn_down → no change on `movement` or `dir_change`. A 4-cycle-stable pulse is accepted.
- Reversal: `movement`=1000, press btn_left → stays 1000, no `dir_change`. Press btn_down → 0010.
- Simultaneous: `movement`=0001, press btn_up, btn_down, btn_left on the same cycle → `movement`=0100. UP is filtered as same direction, DOWN as reversal.
- Start: `movement`=0010, press btn_start and btn_right together → one-cycle `start`, `movement`=0000, `dir_change`=1. Assert reset_n=0 mid-debounce of btn_up → no output events.

Source files
------------

// File: rtl/direction_input.sv
// -----------------------------------------------------------------------------
// direction_input
//
// Button front end for the snake game core. Five raw push buttons (four
// directions plus start) are synchronised into clk, debounced, and turned into
// press events on the rising edge of each debounced level. Direction press
// events update a latched one-hot movement code with reversal filtering. A
// start press emits a single-cycle pulse and clears the movement code.
//
// Parameters
//   DEBOUNCE_CYCLES : consecutive stable samples needed to accept a new level
//                     (must be >= 2)
//   BLOCK_REVERSE   : 1 = a press opposite the current direction is ignored
//
// Ports
//   clk          in   system clock, all logic on the rising edge
//   reset_n      in   asynchronous active-low reset
//   btn_up       in   raw up button, active-high, asynchronous to clk
//   btn_down     in   raw down button
//   btn_left     in   raw left button
//   btn_right    in   raw right button
//   btn_start    in   raw start button
//   movement     out  UP=0001 DOWN=0010 LEFT=0100 RIGHT=1000 none=0000
//   start        out  one-cycle pulse on an accepted start press
//   dir_change   out  one-cycle pulse coincident with every movement change
// -----------------------------------------------------------------------------
module direction_input #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter bit BLOCK_REVERSE   = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_start,
  output logic [3:0] movement,
  output logic       start,
  output logic       dir_change
);

  localparam int NBTN  = 5;
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The flip happens on the sample that would take the count to
  // DEBOUNCE_CYCLES, so the stored count tops out one below that.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit order: 0=up, 1=down, 2=left, 3=right, 4=start. Bits 0..3 line up
  // with the one-hot movement encoding.
  logic [NBTN-1:0] btn_raw;
  assign btn_raw = {btn_start, btn_right, btn_left, btn_down, btn_up};

  wire [NBTN-1:0] press_w;

  // ---------------------------------------------------------------------------
  // Per-button synchroniser, debouncer and rising-edge detector
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < NBTN; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic [CNT_W-1:0] cnt_q;
      logic [CNT_W-1:0] cnt_d;
      logic             level_q;
      logic             level_d;
      logic             level_prev_q;

      // Counter runs only while the synchronised input disagrees with the
      // accepted level; any agreeing sample restarts it, so glitches shorter
      // than DEBOUNCE_CYCLES never move the level.
      always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (sync2_q != level_q) begin
          if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          sync1_q      <= 1'b0;
          sync2_q      <= 1'b0;
          cnt_q        <= '0;
          level_q      <= 1'b0;
          level_prev_q <= 1'b0;
        end else begin
          sync1_q      <= btn_raw[gi];
          sync2_q      <= sync1_q;
          cnt_q        <= cnt_d;
          level_q      <= level_d;
          level_prev_q <= level_q;
        end
      end

      // Press event only on a debounced 0->1; releases are ignored.
      assign press_w[gi] = level_q & ~level_prev_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Direction selection and start handling
  // ---------------------------------------------------------------------------
  logic [3:0] movement_q, movement_d;
  logic       start_q, start_d;
  logic       dir_change_q, dir_change_d;

  logic [3:0] dir_press;
  logic [3:0] opposite;
  logic [3:0] blocked;
  logic [3:0] cand;
  logic [3:0] winner;
  logic       start_press;

  assign dir_press   = press_w[3:0];
  assign start_press = press_w[4];

  // Opposite pairs: up<->down (bits 0/1), left<->right (bits 2/3).
  // With movement=0000 this is 0000, so nothing is excluded for reversal.
  assign opposite = {movement_q[2], movement_q[3], movement_q[0], movement_q[1]};
  assign blocked  = movement_q | (BLOCK_REVERSE ? opposite : 4'b0000);
  assign cand     = dir_press & ~blocked;

  // Fixed priority UP > DOWN > LEFT > RIGHT.
  always_comb begin
    winner = 4'b0000;
    if (cand[0]) begin
      winner = 4'b0001;
    end else if (cand[1]) begin
      winner = 4'b0010;
    end else if (cand[2]) begin
      winner = 4'b0100;
    end else if (cand[3]) begin
      winner = 4'b1000;
    end
  end

  // Start takes precedence and discards any same-cycle direction press.
  always_comb begin
    movement_d   = movement_q;
    start_d      = 1'b0;
    dir_change_d = 1'b0;
    if (start_press) begin
      movement_d   = 4'b0000;
      start_d      = 1'b1;
      dir_change_d = |movement_q;
    end else if (|cand) begin
      movement_d   = winner;
      dir_change_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      movement_q   <= 4'b0000;
      start_q      <= 1'b0;
      dir_change_q <= 1'b0;
    end else begin
      movement_q   <= movement_d;
      start_q      <= start_d;
      dir_change_q <= dir_change_d;
    end
  end

  assign movement   = movement_q;
  assign start      = start_q;
  assign dir_change = dir_change_q;

endmodule
